// File: rtl/icache_direct_pkg.sv
// Shared types and sizing constants for the direct-mapped instruction cache.
package icache_direct_pkg;

    localparam int unsigned WORD_W        = 32;
    localparam int unsigned ICACHE_FRAMES = 16;
    localparam int unsigned ICACHE_IDX_W  = $clog2(ICACHE_FRAMES);
    localparam int unsigned ICACHE_TAG_W  = WORD_W - ICACHE_IDX_W - 2;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } icache_state_t;

    // Byte address split into tag / frame index / byte offset.
    typedef struct packed {
        logic [ICACHE_TAG_W-1:0] tag;
        logic [ICACHE_IDX_W-1:0] idx;
        logic [1:0]              bytoff;
    } icache_addr_t;

endpackage

// File: rtl/icache_direct_if.sv
// Fetch-port and refill-port signals of the instruction cache.
interface icache_direct_if;
    import icache_direct_pkg::*;

    // Datapath side
    logic  imemREN;
    word_t imemaddr;
    logic  ihit;
    word_t imemload;
    logic  iflush;
    // Memory controller side
    logic  iREN;
    word_t iaddr;
    logic  iwait;
    word_t iload;
    // Statistics
    word_t hit_count;
    word_t miss_count;

    // Cache view
    modport slave (
        input  imemREN, imemaddr, iflush, iwait, iload,
        output ihit, imemload, iREN, iaddr, hit_count, miss_count
    );

    // Datapath / memory controller view
    modport master (
        output imemREN, imemaddr, iflush, iwait, iload,
        input  ihit, imemload, iREN, iaddr, hit_count, miss_count
    );

endinterface

// File: rtl/icache_direct_frame_array.sv
// Valid/tag/data storage: one async read port, one write port, flush-clear.
module icache_direct_frame_array
    import icache_direct_pkg::*;
#(
    parameter int unsigned FRAMES = ICACHE_FRAMES,
    parameter int unsigned IDX_W  = $clog2(FRAMES),
    parameter int unsigned TAG_W  = WORD_W - IDX_W - 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic             o_rd_valid,
    output logic [TAG_W-1:0] o_rd_tag,
    output word_t            o_rd_data,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [TAG_W-1:0] i_wr_tag,
    input  word_t            i_wr_data
);

    logic [FRAMES-1:0] r_valid;
    logic [TAG_W-1:0]  r_tag  [FRAMES];
    word_t             r_data [FRAMES];

    logic w_wr_ok;

    // Writes are dropped when reset or flush coincide with a refill.
    assign w_wr_ok = i_wr_en & ~i_rst & ~i_flush;

    // Valid bits: reset and flush clear everything, a refill sets one frame.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_idx] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset; valid gates their use.
    always_ff @(posedge i_clk) begin
        if (w_wr_ok) begin
            r_tag[i_wr_idx]  <= i_wr_tag;
            r_data[i_wr_idx] <= i_wr_data;
        end
    end

    // Combinational read port for same-cycle hits.
    always_comb begin
        o_rd_valid = r_valid[i_rd_idx];
        o_rd_tag   = r_tag[i_rd_idx];
        o_rd_data  = r_data[i_rd_idx];
    end

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-frame instruction cache with a two-state refill FSM.
module icache_direct
    import icache_direct_pkg::*;
#(
    parameter int unsigned FRAMES = ICACHE_FRAMES
) (
    input  logic            CLK,
    input  logic            RST,
    icache_direct_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(FRAMES);
    localparam int unsigned TAG_W = WORD_W - IDX_W - 2;

    localparam logic [0:0] ST_IDLE  = 1'(IDLE);
    localparam logic [0:0] ST_FETCH = 1'(FETCH);

    logic [0:0]       r_state;
    logic [0:0]       w_state_next;
    word_t            r_miss_addr;
    word_t            r_hit_count;
    word_t            r_miss_count;

    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic             w_rd_valid;
    logic [TAG_W-1:0] w_rd_tag;
    word_t            w_rd_data;
    logic             w_fetching;
    logic             w_hit;
    logic             w_miss_start;
    logic             w_fill;
    logic             w_unused;

    // Request address split; byte offset is irrelevant for word fetches.
    assign w_idx    = bus.imemaddr[IDX_W+1:2];
    assign w_tag    = bus.imemaddr[WORD_W-1:IDX_W+2];
    assign w_unused = &{1'b0, bus.imemaddr[1:0]};

    icache_direct_frame_array #(
        .FRAMES (FRAMES),
        .IDX_W  (IDX_W),
        .TAG_W  (TAG_W)
    ) u_frames (
        .i_clk      (CLK),
        .i_rst      (RST),
        .i_flush    (bus.iflush),
        .i_rd_idx   (w_idx),
        .o_rd_valid (w_rd_valid),
        .o_rd_tag   (w_rd_tag),
        .o_rd_data  (w_rd_data),
        .i_wr_en    (w_fill),
        .i_wr_idx   (r_miss_addr[IDX_W+1:2]),
        .i_wr_tag   (r_miss_addr[WORD_W-1:IDX_W+2]),
        .i_wr_data  (bus.iload)
    );

    // Hit detect: only while idle, never during a flush cycle.
    always_comb begin
        w_fetching = (r_state == ST_FETCH);
        w_hit      = bus.imemREN & w_rd_valid & (w_rd_tag == w_tag)
                   & ~w_fetching & ~bus.iflush;
    end

    // Next-state logic; flush overrides everything and aborts a refill.
    always_comb begin
        w_state_next = r_state;
        w_miss_start = 1'b0;
        w_fill       = 1'b0;
        if (bus.iflush) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.imemREN && !w_hit) begin
                        w_miss_start = 1'b1;
                        w_state_next = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (!bus.iwait) begin
                        w_fill       = 1'b1;
                        w_state_next = ST_IDLE;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Latch the word-aligned miss address; held stable for the whole refill.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_miss_addr <= '0;
        end else if (w_miss_start) begin
            r_miss_addr <= {bus.imemaddr[WORD_W-1:2], 2'b00};
        end
    end

    // Wrapping hit/miss statistics; untouched by flush.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (w_hit) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (w_miss_start) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    // Port drive: refill request comes purely from registered state.
    always_comb begin
        bus.ihit       = w_hit;
        bus.imemload   = w_hit ? w_rd_data : '0;
        bus.iREN       = w_fetching;
        bus.iaddr      = w_fetching ? r_miss_addr : '0;
        bus.hit_count  = r_hit_count;
        bus.miss_count = r_miss_count;
    end

endmodule

// File: tb/tb_icache_direct.sv
// Directed, scoreboarded bench for icache_direct.
module tb_icache_direct;
    import icache_direct_pkg::*;

    logic CLK;
    logic RST;

    icache_direct_if bus();

    icache_direct #(.FRAMES(16)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;
    word_t       sb[$];
    word_t       m_hit    = '0;
    word_t       m_miss   = '0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic check_counters(input string name);
        chk({name, "_hit_count"},  bus.hit_count,  m_hit);
        chk({name, "_miss_count"}, bus.miss_count, m_miss);
    endtask

    // Called just after an edge: expects a hit this cycle, pops the scoreboard.
    task automatic expect_hit(input string name);
        word_t e;
        #1;
        chk({name, "_ihit"}, bus.ihit, 1);
        if (sb.size() == 0) begin
            chk({name, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({name, "_imemload"}, bus.imemload, e);
        end
        m_hit++;
        @(posedge CLK); #1;
        bus.imemREN = 1'b0;
        check_counters(name);
    endtask

    task automatic do_hit(input word_t a, input word_t d);
        bus.imemREN  = 1'b1;
        bus.imemaddr = a;
        sb.push_back(d);
        expect_hit("hit");
    endtask

    // Miss from IDLE, optional stall cycles, fill, then same-address hit.
    task automatic do_miss(input word_t a, input word_t d, input int waits);
        word_t wa;
        wa = {a[31:2], 2'b00};
        bus.imemREN  = 1'b1;
        bus.imemaddr = a;
        bus.iwait    = 1'b1;
        bus.iflush   = 1'b0;
        #1;
        chk("miss_ihit", bus.ihit, 0);
        chk("miss_iren_idle", bus.iREN, 0);
        m_miss++;
        @(posedge CLK); #1;
        for (int i = 0; i < waits; i++) begin
            #1;
            chk("stall_iren",  bus.iREN, 1);
            chk("stall_iaddr", bus.iaddr, wa);
            chk("stall_ihit",  bus.ihit, 0);
            @(posedge CLK); #1;
        end
        bus.iwait = 1'b0;
        bus.iload = d;
        #1;
        chk("fetch_iren",  bus.iREN, 1);
        chk("fetch_iaddr", bus.iaddr, wa);
        chk("fetch_ihit",  bus.ihit, 0);
        sb.push_back(d);
        @(posedge CLK); #1;
        bus.iwait = 1'b1;
        bus.iload = '0;
        expect_hit("fill");
    endtask

    initial begin
        word_t ra [4];
        RST          = 1'b1;
        bus.imemREN  = 1'b0;
        bus.imemaddr = '0;
        bus.iflush   = 1'b0;
        bus.iwait    = 1'b1;
        bus.iload    = '0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        #1;
        chk("rst_ihit",     bus.ihit, 0);
        chk("rst_imemload", bus.imemload, 0);
        chk("rst_iren",     bus.iREN, 0);
        chk("rst_iaddr",    bus.iaddr, 0);
        check_counters("rst");

        // Basic miss, fill, hit
        do_miss(32'h0000_0040, 32'h8C22_0004, 0);
        // Stalled refill
        do_miss(32'h0000_0044, 32'h1111_0044, 5);
        // Highest frame
        do_miss(32'h0000_003C, 32'h3C3C_3C3C, 0);
        do_hit (32'h0000_0040, 32'h8C22_0004);

        // Same index, different tag: evict and re-miss
        do_miss(32'h0000_0080, 32'h8080_8080, 0);
        do_miss(32'h0000_0040, 32'h4040_4040, 0);
        chk("conflict_miss_count", bus.miss_count, 32'd5);

        // Address changes while refill in flight
        bus.imemREN  = 1'b1;
        bus.imemaddr = 32'h0000_0048;
        bus.iwait    = 1'b1;
        #1;
        chk("chg_miss_ihit", bus.ihit, 0);
        m_miss++;
        @(posedge CLK); #1;
        bus.imemaddr = 32'h0000_0100;
        #1;
        chk("chg_iren",  bus.iREN, 1);
        chk("chg_iaddr", bus.iaddr, 32'h0000_0048);
        chk("chg_ihit",  bus.ihit, 0);
        @(posedge CLK); #1;
        bus.iwait = 1'b0;
        bus.iload = 32'h4848_4848;
        #1;
        chk("chg_fill_iaddr", bus.iaddr, 32'h0000_0048);
        @(posedge CLK); #1;
        bus.iwait = 1'b1;
        do_miss(32'h0000_0100, 32'h0100_0100, 0);
        do_hit (32'h0000_0048, 32'h4848_4848);

        // Flush in IDLE: next request misses, counters kept
        do_hit(32'h0000_0100, 32'h0100_0100);
        bus.imemREN  = 1'b1;
        bus.imemaddr = 32'h0000_0100;
        bus.iflush   = 1'b1;
        #1;
        chk("flush_ihit",     bus.ihit, 0);
        chk("flush_imemload", bus.imemload, 0);
        @(posedge CLK); #1;
        bus.iflush = 1'b0;
        check_counters("flush");
        do_miss(32'h0000_0100, 32'hABCD_0100, 0);

        // Flush coinciding with refill completion: no fill
        bus.imemREN  = 1'b1;
        bus.imemaddr = 32'h0000_004C;
        bus.iwait    = 1'b1;
        #1;
        chk("ff_miss_ihit", bus.ihit, 0);
        m_miss++;
        @(posedge CLK); #1;
        bus.iwait  = 1'b0;
        bus.iload  = 32'h1234_5678;
        bus.iflush = 1'b1;
        #1;
        chk("ff_iren", bus.iREN, 1);
        @(posedge CLK); #1;
        bus.iflush = 1'b0;
        bus.iwait  = 1'b1;
        #1;
        chk("ff_iren_after", bus.iREN, 0);
        check_counters("ff");
        do_miss(32'h0000_004C, 32'h4C4C_4C4C, 0);

        // Reset mid-refill
        do_miss(32'h0000_0040, 32'h8C22_0004, 0);
        do_miss(32'h0000_0044, 32'h1111_0044, 0);
        do_miss(32'h0000_003C, 32'h3C3C_3C3C, 0);
        bus.imemREN  = 1'b1;
        bus.imemaddr = 32'h0000_0084;
        bus.iwait    = 1'b1;
        #1;
        chk("rstf_miss_ihit", bus.ihit, 0);
        @(posedge CLK); #1;
        chk("rstf_iren", bus.iREN, 1);
        RST       = 1'b1;
        bus.iwait = 1'b0;
        bus.iload = 32'hDEAD_BEEF;
        @(posedge CLK); #1;
        RST         = 1'b0;
        bus.iwait   = 1'b1;
        bus.imemREN = 1'b0;
        m_hit  = '0;
        m_miss = '0;
        #1;
        chk("rstf_iren_after",  bus.iREN, 0);
        chk("rstf_iaddr_after", bus.iaddr, 0);
        check_counters("rstf");
        ra[0] = 32'h0000_0040;
        ra[1] = 32'h0000_0044;
        ra[2] = 32'h0000_003C;
        ra[3] = 32'h0000_0084;
        for (int i = 0; i < 4; i++) begin
            bus.imemREN  = 1'b1;
            bus.imemaddr = ra[i];
            #1;
            chk("rstf_frame_miss", bus.ihit, 0);
            bus.imemREN = 1'b0;
        end
        do_miss(32'h0000_0084, 32'h8484_8484, 0);
        chk("rstf_final_miss_count", bus.miss_count, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, one-word-per-block instruction cache between the datapath fetch port and the memory controller's instruction port.
- Hits return in the same cycle.
- Misses run a two-state refill FSM that drives iREN/iaddr to the memory controller and waits on iwait.
- Data traffic has priority in the controller, so refills may stall for many cycles; the cache tolerates arbitrary iwait duration.

Parameters:
- FRAMES, 16, number of cache frames; power of two, ≥2.
- IDX_W, $clog2(FRAMES), index width; derived, not overridden.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- imemREN  in  1  datapath instruction read request.
- imemaddr  in  32  byte address; bits [1:0] ignored.
- ihit  out  1  requested word valid this cycle.
- imemload  out  32  instruction word; valid when ihit=1.
- iflush  in  1  invalidate all frames.
- iREN  out  1  refill read request to memory controller.
- iaddr  out  32  refill word address, bits [1:0]=00.
- iwait  in  1  memory controller busy; 0 = iload valid this cycle.
- iload  in  32  refill data from memory controller.
- hit_count  out  32  wrapping count of hit cycles.
- miss_count  out  32  wrapping count of misses.

Behaviour:
- Address split: offset = [1:0], index = [IDX_W+1:2], tag = [31:IDX_W+2].
- Storage: valid, tag and data per frame. Only valid and the FSM are reset; data and tag arrays are not.
- Reset:
  - All valid bits clear; state = IDLE.
  - Outputs: ihit=0, imemload=0, iREN=0, iaddr=0, hit_count=0, miss_count=0.
  - Reset asserted during FETCH abandons the refill with no frame write.
- Hit (combinational): ihit = imemREN & valid[index] & (tag[index]==addr tag) & (state==IDLE).
  - imemload = data[index] when ihit, else 0.
- FSM states: IDLE, FETCH.
- IDLE:
  - imemREN & no hit & ~iflush → latch {imemaddr[31:2],00} into miss_addr; miss_count+1; go to FETCH.
  - Otherwise stay in IDLE.
- FETCH:
  - Outputs: iREN=1, iaddr=miss_addr, ihit=0.
  - iwait=0 → write iload, miss_addr tag and valid=1 into frame miss_addr index; go to IDLE.
  - iwait=1 → hold; iREN and iaddr stay stable.
- iREN is registered-state driven, never combinational from imemREN.
- Minimum miss penalty is 3 cycles: detect (IDLE), FETCH with iwait=0, hit in IDLE.
- Request changes during FETCH:
  - If imemaddr changes or imemREN drops, the in-flight refill still completes into the latched frame.
  - The new address is then evaluated in IDLE.
- Conflicting tag at the same index: overwritten on refill; no writeback, since instruction memory is read-only.
- iflush (priority over everything except RST):
  - Clears all valid bits next edge; state → IDLE; any FETCH is aborted with no frame write.
  - ihit=0 in the iflush cycle.
- Simultaneous refill completion and iflush: iflush wins; frame stays invalid.
- Counters:
  - hit_count increments every cycle ihit=1.
  - miss_count increments on each IDLE→FETCH transition.
  - Both wrap at 2^32.
- Counters are not cleared by iflush.

Decomposition:
- Shared package (cpu_types_pkg): icache_state_t enum {IDLE, FETCH}; icache address struct {tag, idx, bytoff} with widths from a FRAMES constant (ICACHE_FRAMES=16).
- Word type comes from the existing word_t.
- One natural sub-module: icache_frame_array, holding the valid/tag/data storage with one read port, one write port and a flush-clear.
- The FSM and counters stay in icache_direct.

Test Plan:
- Reset, then imemREN=1, imemaddr=0x00000040 → ihit=0; next cycle iREN=1, iaddr=0x40. Drive iwait=0 with iload=0x8C220004 → next cycle ihit=1, imemload=0x8C220004, miss_count=1, hit_count=1.
- Refill of 0x44 with iwait=1 for 5 cycles → iREN and iaddr=0x44 stable all 5 cycles; ihit=0 throughout; fill completes on the first iwait=0 cycle.
- Fill 0x40, then request 0x80 (same index at FRAMES=16, different tag) → miss and refill. Re-request 0x40 → miss again; miss_count=3.
- During FETCH for 0x48, change imemaddr to 0x100 before iwait=0 → frame 2 filled with tag of 0x48; next IDLE cycle misses on 0x100.
- Fill 0x40, pulse iflush=1 → next request to 0x40 misses. Separately, iflush together with iwait=0 in FETCH → no fill; state IDLE; counters unchanged by the flush.
- Assert RST for 1 cycle mid-FETCH → next cycle iREN=0, counters=0, all frames miss.
